// File: rtl/crc_check_scheduler.sv
// crc_check_scheduler: round-robin time-sharing of one serial CRC-4 (x^4+x+1)
// syndrome engine among NREQ requesters. Each granted codeword is shifted
// MSB-first through the LFSR in DATA_W cycles; the result is held until taken.
module crc_check_scheduler #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 15,
  parameter int ID_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   data,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ID_W-1:0]          res_id,
  output logic [3:0]               syndrome,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESULT} state_t;

  // Count value on the last (DATA_W-th) shift; cnt is 4 bits wide.
  localparam logic [3:0] LAST = 4'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [3:0]          lfsr_q, lfsr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic                valid_q, valid_d;
  logic [3:0]          syn_q, syn_d;
  logic                err_q, err_d;

  // Arbiter results
  logic                found;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     rr_next;
  logic [ID_W:0]       idx;
  logic [ID_W:0]       nxt;

  // One LFSR step for the current MSB of the shift register
  logic                shift_bit;
  logic [3:0]          lfsr_step;

  // Per-requester view of the flattened codeword bus
  logic [DATA_W-1:0]   lane [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign lane[gi] = data[gi*DATA_W +: DATA_W];
  end

  // Round-robin search: first set request at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NREQ)) idx = idx - (ID_W+1)'(NREQ);
      if (!found && req[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
    nxt = {1'b0, winner} + (ID_W+1)'(1);
    if (nxt == (ID_W+1)'(NREQ)) nxt = '0;
    rr_next = nxt[ID_W-1:0];
  end

  // Galois LFSR step for x^4+x+1: D<=C, C<=B, B<=A^D, A<=b^D.
  always_comb begin
    shift_bit = word_q[DATA_W-1];
    lfsr_step = {lfsr_q[2], lfsr_q[1], lfsr_q[0] ^ lfsr_q[3], shift_bit ^ lfsr_q[3]};
  end

  // Next-state and datapath control for the IDLE/SHIFT/RESULT sequence.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    gnt_d    = '0;
    valid_d  = valid_q;
    syn_d    = syn_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          word_d   = lane[winner];
          lfsr_d   = 4'h0;
          cnt_d    = 4'h0;
          gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << winner;
          id_d     = winner;
          rr_ptr_d = rr_next;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        lfsr_d = lfsr_step;
        word_d = word_q << 1;
        if (cnt_q == LAST) begin
          // Hold cnt at its final value rather than wrapping.
          state_d = RESULT;
          valid_d = 1'b1;
          syn_d   = lfsr_step;
          err_d   = |lfsr_step;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      word_q   <= '0;
      lfsr_q   <= 4'h0;
      cnt_q    <= 4'h0;
      rr_ptr_q <= '0;
      id_q     <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      syn_q    <= 4'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
      syn_q    <= syn_d;
      err_q    <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign res_valid = valid_q;
  assign res_id    = id_q;
  assign syndrome  = syn_q;
  assign err       = err_q;

endmodule

// File: tb/tb_crc_check_scheduler.sv
// Bench for crc_check_scheduler: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model.
module tb_crc_check_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 15;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] data = '0;
  logic              res_ready = 1'b0;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              res_valid;
  logic [IW-1:0]     res_id;
  logic [3:0]        syndrome;
  logic              err;

  crc_check_scheduler #(.NREQ(NREQ), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .syndrome(syndrome), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Remainder of the codeword polynomial modulo x^4+x+1 by long division.
  function automatic logic [3:0] crc15(input logic [14:0] w);
    logic [14:0] r;
    logic [14:0] poly;
    r = w;
    for (int i = 14; i >= 4; i--) begin
      if (r[i]) begin
        poly = 15'h0013 << (i - 4);
        r = r ^ poly;
      end
    end
    return r[3:0];
  endfunction

  // ---------------- transaction-level model ----------------
  // The engine is either free, counting down the shifts still owed for the
  // captured word, or holding a finished result until it is accepted.
  logic            m_free = 1'b1;
  int              m_left = 0;
  int              m_ptr  = 0;
  logic [14:0]     m_word = '0;
  logic [NREQ-1:0] e_gnt  = '0;
  logic            e_valid = 1'b0;
  int              e_id   = 0;
  logic [3:0]      e_syn  = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_free = 1'b1; m_left = 0; m_ptr = 0; m_word = '0;
      e_gnt = '0; e_valid = 1'b0; e_id = 0; e_syn = '0;
    end else begin
      e_gnt = '0;
      if (e_valid) begin
        if (res_ready) begin
          e_valid = 1'b0;
          m_free  = 1'b1;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          e_valid = 1'b1;
          e_syn   = crc15(m_word);
        end
      end else if (m_free && req != 0) begin
        int w;
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        e_gnt  = NREQ'(1) << w;
        e_id   = w;
        m_word = data[w*DW +: DW];
        m_ptr  = (w + 1) % NREQ;
        m_free = 1'b0;
        m_left = DW;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("gnt", gnt, e_gnt);
    chk("busy", busy, !m_free);
    chk("res_valid", res_valid, e_valid);
    chk("res_id", res_id, e_id);
    chk("syndrome", syndrome, e_syn);
    chk("err", err, e_syn != 0);
  end

  // ---------------- stimulus helpers ----------------
  // Advance one cycle; a requester drops its request on seeing its grant.
  task automatic step();
    @(posedge clk);
    #1;
    req = req & ~gnt;
  endtask

  task automatic set_req(input int i, input logic [14:0] w);
    data[i*DW +: DW] = w;
    req[i] = 1'b1;
  endtask

  function automatic logic [14:0] rand_word();
    logic [14:0] w;
    w = 15'($urandom);
    if ($urandom_range(0, 2) == 0) begin
      w[3:0] = 4'h0;
      w[3:0] = crc15(w);
    end
    return w;
  endfunction

  task automatic wait_gnt(input int max, output logic [NREQ-1:0] g, output int cyc);
    g = '0;
    for (cyc = 1; cyc <= max; cyc++) begin
      step();
      if (gnt != 0) begin
        g = gnt;
        return;
      end
    end
    timeout_fail("wait_gnt");
  endtask

  task automatic wait_valid(input int max, output int cyc);
    for (cyc = 1; cyc <= max; cyc++) begin
      step();
      if (res_valid) return;
    end
    timeout_fail("wait_valid");
  endtask

  task automatic wait_idle(input int max);
    for (int c = 0; c < max; c++) begin
      step();
      if (!busy && !res_valid) return;
    end
    timeout_fail("wait_idle");
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    req = '0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] g;
    int c;
    int gcyc [4];
    logic [NREQ-1:0] gval [4];
    int ng;
    logic [14:0] w;

    // Pin the reference division with hand-computed remainders.
    chk("model_0013", crc15(15'h0013), 4'h0);
    chk("model_0001", crc15(15'h0001), 4'h1);
    chk("model_0012", crc15(15'h0012), 4'h1);
    chk("model_0010", crc15(15'h0010), 4'h3);
    chk("model_7fff", crc15(15'h7FFF), 4'h0);

    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_syn", syndrome, 0);
    reset = 1'b1;
    step();

    // Valid codeword from requester 0.
    res_ready = 1'b1;
    set_req(0, 15'h0013);
    wait_gnt(5, g, c);
    chk("t1_gnt", g, 4'b0001);
    wait_valid(20, c);
    chk("t1_latency", c, 15);
    chk("t1_id", res_id, 0);
    chk("t1_syn", syndrome, 4'h0);
    chk("t1_err", err, 0);
    wait_idle(5);

    // Corrupted codeword from requester 2.
    set_req(2, 15'h0012);
    wait_gnt(5, g, c);
    chk("t2_gnt", g, 4'b0100);
    wait_valid(20, c);
    chk("t2_id", res_id, 2);
    chk("t2_syn", syndrome, 4'h1);
    chk("t2_err", err, 1);
    wait_idle(5);

    // All four requesting: grants in order 0..3, 17 cycles apart.
    reset_pulse();
    for (int i = 0; i < NREQ; i++) set_req(i, rand_word());
    ng = 0;
    for (int t = 0; t < 120 && ng < 4; t++) begin
      step();
      if (gnt != 0) begin
        gval[ng] = gnt;
        gcyc[ng] = t;
        ng++;
      end
    end
    if (ng < 4) timeout_fail("t3_grants");
    for (int k = 0; k < ng; k++) begin
      chk("t3_order", gval[k], NREQ'(1) << k);
      if (k > 0) chk("t3_spacing", gcyc[k] - gcyc[k-1], 17);
    end
    wait_idle(40);
    for (int i = 0; i < NREQ; i++) set_req(i, rand_word());
    wait_gnt(5, g, c);
    chk("t3_wrap", g, 4'b0001);
    req = '0;
    wait_idle(40);

    // Result back-pressure with a pending request.
    res_ready = 1'b0;
    w = rand_word();
    set_req(0, w);
    wait_gnt(5, g, c);
    wait_valid(20, c);
    set_req(1, rand_word());
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_hold_syn", syndrome, crc15(w));
      chk("t4_hold_id", res_id, 0);
      chk("t4_no_gnt", gnt, 0);
    end
    res_ready = 1'b1;
    step();
    chk("t4_gnt_r1", gnt, 0);
    step();
    chk("t4_gnt_r2", gnt, 4'b0010);
    wait_idle(40);

    // Asynchronous reset during the 7th shift cycle.
    reset_pulse();
    set_req(0, rand_word());
    wait_gnt(5, g, c);
    repeat (6) step();
    #2;
    reset = 1'b0;
    req = '0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_gnt", gnt, 0);
    chk("t5_valid", res_valid, 0);
    chk("t5_id", res_id, 0);
    chk("t5_syn", syndrome, 0);
    chk("t5_err", err, 0);
    step();
    step();
    reset = 1'b1;
    repeat (20) step();
    chk("t5_no_result", res_valid, 0);
    set_req(1, 15'h0001);
    wait_gnt(5, g, c);
    chk("t5_gnt1", g, 4'b0010);
    wait_valid(20, c);
    chk("t5_latency", c, 15);
    chk("t5_syn1", syndrome, 4'h1);
    chk("t5_id1", res_id, 1);
    wait_idle(5);

    // Fairness: simultaneous 0 and 1, then 0 returns before 1 is served.
    reset_pulse();
    set_req(0, rand_word());
    set_req(1, rand_word());
    wait_gnt(5, g, c);
    chk("t6_first", g, 4'b0001);
    wait_valid(20, c);
    set_req(0, rand_word());
    wait_gnt(5, g, c);
    chk("t6_second", g, 4'b0010);
    wait_valid(20, c);
    req = '0;
    wait_idle(40);

    // Randomized traffic with a mid-run asynchronous reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (cyc == 1500) begin
        #1;
        reset = 1'b0;
        req = '0;
      end else if (cyc == 1503) begin
        reset = 1'b1;
      end
      if (reset) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req[i] && $urandom_range(0, 7) == 0) set_req(i, rand_word());
          else if (req[i] && $urandom_range(0, 63) == 0) req[i] = 1'b0;
        end
        res_ready = ($urandom_range(0, 3) != 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
